// File: rtl/cache_trace_arbiter.sv
// Round-robin arbiter that shares one cache-simulator port among NUM_CORES trace
// streams. It also keeps per-core hit/miss counters and a completion watchdog.
module cache_trace_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
  output logic [NUM_CORES-1:0]          req_ack,
  output logic                          req_hit,
  output logic                          trace_ready,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          found_in_cache,
  input  logic                          updated,
  output logic [NUM_CORES*32-1:0]       hit_count,
  output logic [NUM_CORES*32-1:0]       miss_count,
  output logic [$clog2(NUM_CORES)-1:0]  grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int ID_W = $clog2(NUM_CORES);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic WD_EN = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_CORES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RETIRE = 2'd3;

  logic [1:0]                   state_r;
  logic [ID_W-1:0]              rr_ptr_r;
  logic [ID_W-1:0]              grant_id_r;
  logic [ADDR_W-1:0]            mem_addr_r;
  logic                         trace_ready_r;
  logic [NUM_CORES-1:0]         req_ack_r;
  logic                         req_hit_r;
  logic                         busy_r;
  logic                         timeout_err_r;
  logic [WD_W-1:0]              wd_cnt_r;
  logic [NUM_CORES-1:0][31:0]   hit_cnt_r;
  logic [NUM_CORES-1:0][31:0]   miss_cnt_r;

  logic                         pick_found_s;
  logic [ID_W-1:0]              pick_id_s;
  logic [ADDR_W-1:0]            pick_addr_s;
  logic                         done_s;
  logic                         wd_expired_s;

  // Round-robin pick: lowest requester at or above rr_ptr, otherwise lowest overall (wrap).
  always_comb begin
    pick_found_s = 1'b0;
    pick_id_s    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!pick_found_s && req_valid[i] && (ID_W'(i) >= rr_ptr_r)) begin
        pick_found_s = 1'b1;
        pick_id_s    = ID_W'(i);
      end else begin
        pick_found_s = pick_found_s;
        pick_id_s    = pick_id_s;
      end
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!pick_found_s && req_valid[i]) begin
        pick_found_s = 1'b1;
        pick_id_s    = ID_W'(i);
      end else begin
        pick_found_s = pick_found_s;
        pick_id_s    = pick_id_s;
      end
    end
  end

  // Selected-core address mux plus completion and watchdog decode.
  always_comb begin
    pick_addr_s = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (ID_W'(i) == pick_id_s) begin
        pick_addr_s = req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        pick_addr_s = pick_addr_s;
      end
    end
    done_s = found_in_cache | updated;
    if (WD_EN) begin
      wd_expired_s = (wd_cnt_r == WD_LAST);
    end else begin
      wd_expired_s = 1'b0;
    end
  end

  // Transaction FSM, handshake outputs, watchdog and per-core statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= '0;
      grant_id_r    <= '0;
      mem_addr_r    <= '0;
      trace_ready_r <= 1'b0;
      req_ack_r     <= '0;
      req_hit_r     <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      wd_cnt_r      <= '0;
      hit_cnt_r     <= '0;
      miss_cnt_r    <= '0;
    end else begin
      trace_ready_r <= 1'b0;
      req_ack_r     <= '0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant_id_r    <= pick_id_s;
            mem_addr_r    <= pick_addr_s;
            trace_ready_r <= 1'b1;
            busy_r        <= 1'b1;
            state_r       <= ST_ISSUE;
          end else begin
            busy_r        <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wd_cnt_r <= '0;
          state_r  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_s) begin
            // A simultaneous found_in_cache/updated is a hit.
            req_ack_r[grant_id_r] <= 1'b1;
            req_hit_r             <= found_in_cache;
            if (found_in_cache) begin
              hit_cnt_r[grant_id_r] <= hit_cnt_r[grant_id_r] + 32'd1;
            end else begin
              miss_cnt_r[grant_id_r] <= miss_cnt_r[grant_id_r] + 32'd1;
            end
            state_r <= ST_RETIRE;
          end else if (wd_expired_s) begin
            req_ack_r[grant_id_r] <= 1'b1;
            req_hit_r             <= 1'b0;
            timeout_err_r         <= 1'b1;
            state_r               <= ST_RETIRE;
          end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
            state_r  <= ST_WAIT;
          end
        end
        ST_RETIRE: begin
          rr_ptr_r  <= (grant_id_r == LAST_ID) ? '0 : (grant_id_r + ID_W'(1));
          req_hit_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack     = req_ack_r;
  assign req_hit     = req_hit_r;
  assign trace_ready = trace_ready_r;
  assign mem_addr    = mem_addr_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign hit_count   = hit_cnt_r;
  assign miss_count  = miss_cnt_r;

endmodule

// File: tb/tb_cache_trace_arbiter.sv
// Scoreboard bench for cache_trace_arbiter: directed requests, a scripted cache
// responder, and a monitor that checks every ack against queued expectations.
module tb_cache_trace_arbiter;

  localparam int NC  = 4;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic              clk;
  logic              rst;
  logic [NC-1:0]     req_valid;
  logic [NC*AW-1:0]  req_addr;
  logic [NC-1:0]     req_ack;
  logic              req_hit;
  logic              trace_ready;
  logic [AW-1:0]     mem_addr;
  logic              found_in_cache;
  logic              updated;
  logic [NC*32-1:0]  hit_count;
  logic [NC*32-1:0]  miss_count;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  typedef struct {
    int          core;
    logic        hit;
    logic [31:0] addr;
    bit          tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          want[NC]   = '{default: 0};
  int          start[NC]  = '{default: 0};
  int          served[NC] = '{default: 0};
  logic [31:0] base[NC]   = '{default: 32'h0};
  int          resp_mode = 0;   // 0 silent, 1 hit, 2 miss, 3 both strobes
  int          resp_delay = 1;
  int          done_cyc = 0;
  int          tr_count = 0;
  int          tr_last = -100;
  int          min_gap = 1000;
  int          tr0;

  cache_trace_arbiter #(
    .NUM_CORES(NC),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_ack(req_ack),
    .req_hit(req_hit),
    .trace_ready(trace_ready),
    .mem_addr(mem_addr),
    .found_in_cache(found_in_cache),
    .updated(updated),
    .hit_count(hit_count),
    .miss_count(miss_count),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_push(input int core, input logic hit, input logic [31:0] addr, input bit tmo);
    exp_t e;
    e.core = core;
    e.hit  = hit;
    e.addr = addr;
    e.tmo  = tmo;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int core, input logic [31:0] addr, input int n);
    base[core]  = addr;
    start[core] = served[core];
    want[core]  = served[core] + n;
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((exp_q.size() != 0 || busy) && k < max_cyc);
    chk("drain_bound", 128'(k < max_cyc), 128'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Requesters: hold address until acked, then advance by one line or drop valid.
  initial begin
    req_valid = '0;
    req_addr  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
        if (req_ack[i] && served[i] < want[i]) served[i]++;
        req_valid[i] = (served[i] < want[i]);
        req_addr[i*AW +: AW] = base[i] + 32'((served[i] - start[i]) * 64);
      end
    end
  end

  // Cache model: answers resp_delay cycles after each trace_ready pulse.
  initial begin
    found_in_cache = 1'b0;
    updated        = 1'b0;
    forever begin
      @(negedge clk);
      if (trace_ready && resp_mode != 0) begin
        repeat (resp_delay) @(negedge clk);
        found_in_cache = (resp_mode == 1 || resp_mode == 3);
        updated        = (resp_mode == 2 || resp_mode == 3);
        done_cyc       = cyc;
        @(negedge clk);
        found_in_cache = 1'b0;
        updated        = 1'b0;
      end
    end
  end

  // Monitor: issue-strobe shape/spacing, and every ack popped against the scoreboard.
  initial begin
    exp_t e;
    logic tr_prev;
    tr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (trace_ready) begin
        chk("trace_ready_width", 128'(tr_prev), 128'd0);
        chk("busy_during_issue", 128'(busy), 128'd1);
        if (!tr_prev) begin
          tr_count++;
          if (cyc - tr_last < min_gap) min_gap = cyc - tr_last;
          tr_last = cyc;
        end
      end
      tr_prev = trace_ready;
      if (req_ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 128'(req_ack), 128'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_vector", 128'(req_ack), 128'(1 << e.core));
          chk("ack_hit", 128'(req_hit), 128'(e.hit));
          chk("grant_id", 128'(grant_id), 128'(e.core));
          chk("mem_addr", 128'(mem_addr), 128'(e.addr));
          if (e.tmo) chk("timeout_latency", 128'(cyc - tr_last), 128'(TMO + 1));
          else       chk("ack_latency", 128'(cyc - done_cyc), 128'd1);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_trace_ready", 128'(trace_ready), 128'd0);
    chk("rst_req_ack", 128'(req_ack), 128'd0);
    chk("rst_req_hit", 128'(req_hit), 128'd0);
    chk("rst_grant_id", 128'(grant_id), 128'd0);
    chk("rst_mem_addr", 128'(mem_addr), 128'd0);
    chk("rst_timeout_err", 128'(timeout_err), 128'd0);
    chk("rst_hit_count", hit_count, 128'd0);
    chk("rst_miss_count", miss_count, 128'd0);

    // Single hit on core 0, cache answers 3 cycles after issue
    tr0 = tr_count;
    resp_mode = 1; resp_delay = 3;
    exp_push(0, 1'b1, 32'h0000_1040, 1'b0);
    issue(0, 32'h0000_1040, 1);
    drain(200);
    chk("t1_hit0", 128'(hit_count[31:0]), 128'd1);
    chk("t1_miss0", 128'(miss_count[31:0]), 128'd0);
    chk("t1_pulses", 128'(tr_count - tr0), 128'd1);

    // Cores 1 and 3 together from reset, both misses, served 1 then 3
    do_reset();
    resp_mode = 2; resp_delay = 2;
    exp_push(1, 1'b0, 32'h0000_2000, 1'b0);
    exp_push(3, 1'b0, 32'h0000_3000, 1'b0);
    issue(1, 32'h0000_2000, 1);
    issue(3, 32'h0000_3000, 1);
    drain(200);
    chk("t2_miss", miss_count, {32'd1, 32'd0, 32'd1, 32'd0});
    chk("t2_hit", hit_count, 128'd0);

    // All four cores, three transactions each, fastest cache response
    tr0 = tr_count;
    resp_mode = 1; resp_delay = 1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NC; i++)
        exp_push(i, 1'b1, 32'h0001_0000 + 32'(i) * 32'h1000 + 32'(k) * 32'h40, 1'b0);
    for (int i = 0; i < NC; i++) issue(i, 32'h0001_0000 + 32'(i) * 32'h1000, 3);
    drain(1000);
    chk("t3_hit", hit_count, {32'd3, 32'd3, 32'd3, 32'd3});
    chk("t3_miss", miss_count, {32'd1, 32'd0, 32'd1, 32'd0});
    chk("t3_pulses", 128'(tr_count - tr0), 128'd12);
    chk("t3_min_gap", 128'(min_gap), 128'd4);
    for (int i = 0; i < NC; i++) chk("t3_acks_per_core", 128'(served[i] - start[i]), 128'd3);

    // Hit and update in the same cycle count as a hit only
    resp_mode = 3; resp_delay = 2;
    exp_push(2, 1'b1, 32'h0000_4400, 1'b0);
    issue(2, 32'h0000_4400, 1);
    drain(200);
    chk("t4_hit", hit_count, {32'd3, 32'd4, 32'd3, 32'd3});
    chk("t4_miss", miss_count, {32'd1, 32'd0, 32'd1, 32'd0});

    // Silent cache: watchdog retires as a miss-less timeout, then normal service
    resp_mode = 0;
    exp_push(1, 1'b0, 32'h0000_5000, 1'b1);
    issue(1, 32'h0000_5000, 1);
    drain(200);
    chk("t5_timeout_err", 128'(timeout_err), 128'd1);
    chk("t5_hit", hit_count, {32'd3, 32'd4, 32'd3, 32'd3});
    chk("t5_miss", miss_count, {32'd1, 32'd0, 32'd1, 32'd0});
    resp_mode = 1; resp_delay = 2;
    exp_push(1, 1'b1, 32'h0000_6000, 1'b0);
    issue(1, 32'h0000_6000, 1);
    drain(200);
    chk("t5_hit_after", hit_count, {32'd3, 32'd4, 32'd4, 32'd3});
    chk("t5_timeout_sticky", 128'(timeout_err), 128'd1);

    // Reset during WAIT; the late update must be ignored
    tr0 = tr_count;
    resp_mode = 2; resp_delay = 3;
    issue(0, 32'h0000_7000, 1);
    begin
      int k = 0;
      while (!trace_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t6_issue_seen", 128'(trace_ready), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    want[0] = served[0];
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_grant_id", 128'(grant_id), 128'd0);
    chk("t6_hit", hit_count, 128'd0);
    chk("t6_miss", miss_count, 128'd0);
    chk("t6_timeout_err", 128'(timeout_err), 128'd0);
    chk("t6_pulses", 128'(tr_count - tr0), 128'd1);
    chk("t6_no_pending", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
